layer_sequencer: RTL

- Controller that runs a chain of up to MAX_LAYERS linear-layer passes on one linear-layer engine over the shared memory bus.
- Per layer, it drives the engine's base addresses from a small descriptor table, pulses the engine's active-high reset, pulses start, and waits for the engine's done.
- It advances layer by layer, so layer k's output_base is normally layer k+1's activ_base.
- It sits between the top-level host/config logic and the layer engine. It never touches address_bus/data_bus itself.

---
 rtl/layer_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Sequences a chain of linear-layer passes on one engine: per layer it loads base
// addresses from a descriptor table, pulses the engine reset, then start, and waits for done.
module layer_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_LAYERS = 4,
    parameter int LIDX_WIDTH = 2,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [LIDX_WIDTH-1:0] cfg_layer,
    input  logic [1:0]            cfg_field,
    input  logic [ADDR_WIDTH-1:0] cfg_data,
    input  logic [LIDX_WIDTH:0]   num_layers,
    input  logic [TMO_WIDTH-1:0]  tmo_limit,
    input  logic                  run,
    input  logic                  abort,
    input  logic                  layer_done,
    output logic                  layer_rst,
    output logic                  layer_start,
    output logic [ADDR_WIDTH-1:0] activ_base,
    output logic [ADDR_WIDTH-1:0] weight_base,
    output logic [ADDR_WIDTH-1:0] bias_base,
    output logic [ADDR_WIDTH-1:0] output_base,
    output logic [LIDX_WIDTH-1:0] cur_layer,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LRST, S_START, S_WAIT, S_NEXT, S_FINISH, S_FAIL
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] activ_tbl  [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0] weight_tbl [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0] bias_tbl   [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0] output_tbl [MAX_LAYERS];
    logic [LIDX_WIDTH:0]   nl_q;
    logic [TMO_WIDTH-1:0]  wdog;

    logic cfg_ok;
    logic nl_ok;
    logic last_layer;
    logic expired;

    assign cfg_ok     = (state == S_IDLE) && cfg_we && (32'(cfg_layer) < MAX_LAYERS);
    assign nl_ok      = (num_layers != '0) && (32'(num_layers) <= MAX_LAYERS);
    assign last_layer = ({1'b0, cur_layer} == nl_q - (LIDX_WIDTH + 1)'(1));
    assign expired    = (tmo_limit != '0) && (wdog == tmo_limit - TMO_WIDTH'(1));

    // NOTE: the descriptor table is small register storage that must read back as zero
    // after reset, so every entry is cleared explicitly rather than left to a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                activ_tbl[i]  <= '0;
                weight_tbl[i] <= '0;
                bias_tbl[i]   <= '0;
                output_tbl[i] <= '0;
            end
        end else if (cfg_ok) begin
            case (cfg_field)
                2'd0: activ_tbl[cfg_layer]  <= cfg_data;
                2'd1: weight_tbl[cfg_layer] <= cfg_data;
                2'd2: bias_tbl[cfg_layer]   <= cfg_data;
                2'd3: output_tbl[cfg_layer] <= cfg_data;
            endcase
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every register samples
    // the pre-edge values; the pulse outputs default low and are raised only on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            layer_rst   <= 1'b0;
            layer_start <= 1'b0;
            activ_base  <= '0;
            weight_base <= '0;
            bias_base   <= '0;
            output_base <= '0;
            cur_layer   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            nl_q        <= '0;
            wdog        <= '0;
        end else begin
            layer_rst   <= 1'b0;
            layer_start <= 1'b0;
            done        <= 1'b0;
            if (abort && state != S_IDLE) begin
                layer_rst <= 1'b1;
                busy      <= 1'b0;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            if (nl_ok) begin
                                nl_q      <= num_layers;
                                cur_layer <= '0;
                                error     <= 1'b0;
                                layer_rst <= 1'b1;
                                busy      <= 1'b1;
                                state     <= S_LRST;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    S_LRST: begin
                        activ_base  <= activ_tbl[cur_layer];
                        weight_base <= weight_tbl[cur_layer];
                        bias_base   <= bias_tbl[cur_layer];
                        output_base <= output_tbl[cur_layer];
                        layer_start <= 1'b1;
                        state       <= S_START;
                    end
                    S_START: begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A done in the expiry cycle still completes the layer.
                        if (layer_done) begin
                            state <= S_NEXT;
                        end else begin
                            wdog <= wdog + TMO_WIDTH'(1);
                            if (expired) begin
                                layer_rst <= 1'b1;
                                error     <= 1'b1;
                                state     <= S_FAIL;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (last_layer) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            cur_layer <= cur_layer + LIDX_WIDTH'(1);
                            layer_rst <= 1'b1;
                            state     <= S_LRST;
                        end
                    end
                    S_FINISH, S_FAIL: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
